// File: rtl/reservation_station_pkg.sv
// Shared definitions for the integer reservation station: tag and data widths,
// boolean constants and the internal op encoding seen on the dispatch/ALU buses.
package reservation_station_pkg;

  localparam int ROB_TAG_W = 4;
  localparam int OP_CODE_W = 6;
  localparam int DATALEN   = 32;
  localparam int ADDR_HI   = 31;
  localparam int ADDR_LO   = 0;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // R-type
  localparam logic [OP_CODE_W-1:0] OP_ADD   = 6'd1;
  localparam logic [OP_CODE_W-1:0] OP_SUB   = 6'd2;
  localparam logic [OP_CODE_W-1:0] OP_SLL   = 6'd3;
  localparam logic [OP_CODE_W-1:0] OP_SLT   = 6'd4;
  localparam logic [OP_CODE_W-1:0] OP_SLTU  = 6'd5;
  localparam logic [OP_CODE_W-1:0] OP_XOR   = 6'd6;
  localparam logic [OP_CODE_W-1:0] OP_SRL   = 6'd7;
  localparam logic [OP_CODE_W-1:0] OP_SRA   = 6'd8;
  localparam logic [OP_CODE_W-1:0] OP_OR    = 6'd9;
  localparam logic [OP_CODE_W-1:0] OP_AND   = 6'd10;
  // I-type arithmetic
  localparam logic [OP_CODE_W-1:0] OP_ADDI  = 6'd11;
  localparam logic [OP_CODE_W-1:0] OP_SLTI  = 6'd12;
  localparam logic [OP_CODE_W-1:0] OP_SLTIU = 6'd13;
  localparam logic [OP_CODE_W-1:0] OP_XORI  = 6'd14;
  localparam logic [OP_CODE_W-1:0] OP_ORI   = 6'd15;
  localparam logic [OP_CODE_W-1:0] OP_ANDI  = 6'd16;
  localparam logic [OP_CODE_W-1:0] OP_SLLI  = 6'd17;
  localparam logic [OP_CODE_W-1:0] OP_SRLI  = 6'd18;
  localparam logic [OP_CODE_W-1:0] OP_SRAI  = 6'd19;
  // Upper immediates
  localparam logic [OP_CODE_W-1:0] OP_LUI   = 6'd20;
  localparam logic [OP_CODE_W-1:0] OP_AUIPC = 6'd21;
  // Branches
  localparam logic [OP_CODE_W-1:0] OP_BEQ   = 6'd22;
  localparam logic [OP_CODE_W-1:0] OP_BNE   = 6'd23;
  localparam logic [OP_CODE_W-1:0] OP_BLT   = 6'd24;
  localparam logic [OP_CODE_W-1:0] OP_BGE   = 6'd25;
  localparam logic [OP_CODE_W-1:0] OP_BLTU  = 6'd26;
  localparam logic [OP_CODE_W-1:0] OP_BGEU  = 6'd27;
  // Jumps
  localparam logic [OP_CODE_W-1:0] OP_JAL   = 6'd28;
  localparam logic [OP_CODE_W-1:0] OP_JALR  = 6'd29;

endpackage

// File: rtl/reservation_station_select.sv
// Lowest-index priority encoder: turns an N-bit request vector into the index
// of the lowest set bit plus a found flag.
module rs_select #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves
    // idx/found unassigned and no latch is inferred.
    idx   = '0;
    found = 1'b0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Out-of-order issue buffer between dispatch and the ALU: holds renamed ops,
// snoops the ALU/LSB broadcast buses and sends one ready op per cycle.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = ROB_TAG_W,
  parameter int OP_W    = OP_CODE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rollback,

  input  logic             issue_valid,
  input  logic [OP_W-1:0]  issue_op,
  input  logic [31:0]      issue_pc,
  input  logic [31:0]      issue_imm,
  input  logic [ROB_W-1:0] issue_rd_rename,
  input  logic             issue_rs1_ready,
  input  logic [31:0]      issue_rs1_value,
  input  logic [ROB_W-1:0] issue_rs1_tag,
  input  logic             issue_rs2_ready,
  input  logic [31:0]      issue_rs2_value,
  input  logic [ROB_W-1:0] issue_rs2_tag,
  output logic             rs_full,

  input  logic             alu_cdb_valid,
  input  logic [ROB_W-1:0] alu_cdb_tag,
  input  logic [31:0]      alu_cdb_value,
  input  logic             lsb_cdb_valid,
  input  logic [ROB_W-1:0] lsb_cdb_tag,
  input  logic [31:0]      lsb_cdb_value,

  output logic             alu_enable,
  output logic [OP_W-1:0]  alu_op,
  output logic [31:0]      alu_pc,
  output logic [31:0]      alu_imm,
  output logic [31:0]      alu_rs1_value,
  output logic [31:0]      alu_rs2_value,
  output logic [ROB_W-1:0] alu_rd_rename
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;

  // Entry state: busy/ready as vectors, payload as per-entry arrays.
  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] rs1_rdy;
  logic [RS_SIZE-1:0] rs2_rdy;
  logic [OP_W-1:0]    op_q      [RS_SIZE];
  logic [31:0]        pc_q      [RS_SIZE];
  logic [31:0]        imm_q     [RS_SIZE];
  logic [ROB_W-1:0]   rd_q      [RS_SIZE];
  logic [31:0]        rs1_val_q [RS_SIZE];
  logic [ROB_W-1:0]   rs1_tag_q [RS_SIZE];
  logic [31:0]        rs2_val_q [RS_SIZE];
  logic [ROB_W-1:0]   rs2_tag_q [RS_SIZE];

  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic [RS_SIZE-1:0] busy_next;

  logic [IDX_W-1:0]   free_idx;
  logic               free_found;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_found;

  logic               advance;
  logic               do_alloc;
  logic               do_disp;

  logic               fwd_rs1_rdy;
  logic [31:0]        fwd_rs1_val;
  logic               fwd_rs2_rdy;
  logic [31:0]        fwd_rs2_val;

  rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_sel (
    .req   (~busy),
    .idx   (free_idx),
    .found (free_found)
  );

  rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_ready_sel (
    .req   (busy & rs1_rdy & rs2_rdy),
    .idx   (sel_idx),
    .found (sel_found)
  );

  // State only moves when the core is running and no flush is in progress.
  assign advance  = rdy && !rollback;
  assign do_alloc = issue_valid && !rs_full && free_found;
  assign do_disp  = sel_found;

  // Same-cycle forwarding for the incoming op; the ALU bus wins a tie.
  always_comb begin
    fwd_rs1_rdy = issue_rs1_ready;
    fwd_rs1_val = issue_rs1_value;
    fwd_rs2_rdy = issue_rs2_ready;
    fwd_rs2_val = issue_rs2_value;
    if (!issue_rs1_ready) begin
      if (alu_cdb_valid && issue_rs1_tag == alu_cdb_tag) begin
        fwd_rs1_rdy = 1'b1;
        fwd_rs1_val = alu_cdb_value;
      end else if (lsb_cdb_valid && issue_rs1_tag == lsb_cdb_tag) begin
        fwd_rs1_rdy = 1'b1;
        fwd_rs1_val = lsb_cdb_value;
      end
    end
    if (!issue_rs2_ready) begin
      if (alu_cdb_valid && issue_rs2_tag == alu_cdb_tag) begin
        fwd_rs2_rdy = 1'b1;
        fwd_rs2_val = alu_cdb_value;
      end else if (lsb_cdb_valid && issue_rs2_tag == lsb_cdb_tag) begin
        fwd_rs2_rdy = 1'b1;
        fwd_rs2_val = lsb_cdb_value;
      end
    end
  end

  always_comb begin
    busy_next = busy;
    if (do_alloc) busy_next[free_idx] = 1'b1;
    if (do_disp)  busy_next[sel_idx]  = 1'b0;
    count_next = count + CNT_W'(do_alloc) - CNT_W'(do_disp);
  end

  // NOTE: the payload arrays carry no reset; busy alone qualifies an entry,
  // so clearing busy on reset or rollback is enough to invalidate everything.
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && !rs1_rdy[i]) begin
          if (alu_cdb_valid && rs1_tag_q[i] == alu_cdb_tag) begin
            rs1_rdy[i]   <= 1'b1;
            rs1_val_q[i] <= alu_cdb_value;
          end else if (lsb_cdb_valid && rs1_tag_q[i] == lsb_cdb_tag) begin
            rs1_rdy[i]   <= 1'b1;
            rs1_val_q[i] <= lsb_cdb_value;
          end
        end
        if (busy[i] && !rs2_rdy[i]) begin
          if (alu_cdb_valid && rs2_tag_q[i] == alu_cdb_tag) begin
            rs2_rdy[i]   <= 1'b1;
            rs2_val_q[i] <= alu_cdb_value;
          end else if (lsb_cdb_valid && rs2_tag_q[i] == lsb_cdb_tag) begin
            rs2_rdy[i]   <= 1'b1;
            rs2_val_q[i] <= lsb_cdb_value;
          end
        end
      end
      // The free slot is never busy, so it never collides with a wake-up.
      if (do_alloc) begin
        op_q[free_idx]      <= issue_op;
        pc_q[free_idx]      <= issue_pc;
        imm_q[free_idx]     <= issue_imm;
        rd_q[free_idx]      <= issue_rd_rename;
        rs1_rdy[free_idx]   <= fwd_rs1_rdy;
        rs1_val_q[free_idx] <= fwd_rs1_val;
        rs1_tag_q[free_idx] <= issue_rs1_tag;
        rs2_rdy[free_idx]   <= fwd_rs2_rdy;
        rs2_val_q[free_idx] <= fwd_rs2_val;
        rs2_tag_q[free_idx] <= issue_rs2_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy          <= '0;
      count         <= '0;
      rs_full       <= 1'b0;
      alu_enable    <= 1'b0;
      alu_op        <= '0;
      alu_pc        <= '0;
      alu_imm       <= '0;
      alu_rs1_value <= '0;
      alu_rs2_value <= '0;
      alu_rd_rename <= '0;
    end else if (!rdy) begin
      alu_enable <= 1'b0;
    end else if (rollback) begin
      busy       <= '0;
      count      <= '0;
      rs_full    <= 1'b0;
      alu_enable <= 1'b0;
    end else begin
      busy       <= busy_next;
      count      <= count_next;
      rs_full    <= (count_next == CNT_W'(RS_SIZE));
      alu_enable <= do_disp;
      // Without a candidate the data outputs keep their last value.
      if (do_disp) begin
        alu_op        <= op_q[sel_idx];
        alu_pc        <= pc_q[sel_idx];
        alu_imm       <= imm_q[sel_idx];
        alu_rs1_value <= rs1_val_q[sel_idx];
        alu_rs2_value <= rs2_val_q[sel_idx];
        alu_rd_rename <= rd_q[sel_idx];
      end
    end
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Out-of-order issue buffer for integer/branch/jump ops, sitting between the decoder/dispatch stage and the ALU.
- Holds up to RS_SIZE renamed instructions and snoops the ALU and LSB broadcast buses to wake waiting operands.
- Each cycle it sends at most one ready entry to the ALU with registered outputs.

Parameters:
- RS_SIZE, 16, number of entries (power of 2)
- ROB_W, 4, width of a ROB rename tag
- OP_W, 6, width of the internal op encoding

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global ready; low = freeze
- rollback  in  1  branch-mispredict flush from ROB
- issue_valid  in  1  dispatch presents an instruction
- issue_op  in  OP_W  op code
- issue_pc  in  32  instruction PC
- issue_imm  in  32  sign-extended immediate
- issue_rd_rename  in  ROB_W  destination ROB tag
- issue_rs1_ready  in  1  rs1 value valid
- issue_rs1_value  in  32  rs1 value
- issue_rs1_tag  in  ROB_W  rs1 producer tag
- issue_rs2_ready  in  1  rs2 value valid
- issue_rs2_value  in  32  rs2 value
- issue_rs2_tag  in  ROB_W  rs2 producer tag
- rs_full  out  1  no free entry
- alu_cdb_valid  in  1  ALU broadcast valid
- alu_cdb_tag  in  ROB_W  ALU broadcast tag
- alu_cdb_value  in  32  ALU broadcast value
- lsb_cdb_valid  in  1  LSB broadcast valid
- lsb_cdb_tag  in  ROB_W  LSB broadcast tag
- lsb_cdb_value  in  32  LSB broadcast value
- alu_enable  out  1  ALU operation valid this cycle
- alu_op  out  OP_W  op code
- alu_pc  out  32  instruction PC
- alu_imm  out  32  immediate
- alu_rs1_value  out  32  operand 1
- alu_rs2_value  out  32  operand 2
- alu_rd_rename  out  ROB_W  destination tag

Behaviour:
- Reset (async, rst=1):
  - all entries invalid; rs_full=0
  - alu_enable=0; all other ALU outputs 0
- Entry contents: busy, op, pc, imm, rd tag, and for each of rs1/rs2 a ready bit, value and tag.
- rdy=0: no state change, no entry allocated or freed, alu_enable held 0 at the next edge.
- Issue:
  - On issue_valid && !rs_full, write the lowest-index free entry.
  - Same-cycle forwarding: a non-ready operand whose tag matches a valid CDB this cycle is stored ready with the CDB value.
  - ALU bus has priority if both CDBs match the same tag; they never legally do.
  - issue_valid while rs_full: instruction dropped; dispatch must not do this.
- Wake-up: every busy entry with a non-ready operand whose tag equals a valid CDB tag captures the value and sets ready at the clock edge.
- Select:
  - Combinational over registered state: the lowest-index busy entry with both operands ready.
  - An entry woken at edge t is eligible from cycle t onward, i.e. the cycle after the broadcast.
- Dispatch:
  - At the edge, the selected entry's fields are copied to the alu_* outputs, alu_enable=1, and the entry is freed.
  - With no candidate, alu_enable=0 and the other outputs hold their last value.
  - Latency: issue with both operands ready at edge t gives alu_enable=1 after edge t+1 at the earliest.
- rs_full:
  - Registered; reflects the entry count after the current edge's allocate/free.
  - A free and an allocate in the same cycle leave the count unchanged.
- rollback: at the edge, all entries become invalid, alu_enable=0, and rs_full=0. Rollback has priority over issue, wake-up and dispatch in that cycle.
- rs1/rs2 for ops without them (LUI, AUIPC, JAL, I-type rs2): dispatch marks them ready with value 0; the RS does not special-case them.

Decomposition:
- Shared define.v: ROB tag width, OP encodings (ADD…JALR), TRUE/FALSE, DATALEN/ADDR ranges. No new typedefs.
- One sub-module, rs_select: a parametric lowest-index priority encoder (RS_SIZE-bit request → index + found flag).
  - Instantiated twice: once for the free slot, once for the ready entry.

Test Plan:
- Reset mid-run: fill 3 entries, pulse rst asynchronously → alu_enable=0 and rs_full=0 immediately; nothing is dispatched afterwards.
- Ready issue: ADDI rd=5, rs1_value=7, imm=3, both ready → alu_enable=1 next cycle with alu_rs1_value=7, alu_imm=3, alu_rd_rename=5.
- Wake-up: ADD rs1 tag=2 not ready, then alu_cdb_valid tag=2 value=0x10 → dispatch the cycle after the broadcast with alu_rs1_value=0x10.
- Same-cycle forward: issue with rs2 tag=9 while lsb_cdb tag=9 value=0xABCD → entry stored ready; dispatched next cycle with rs2=0xABCD.
- Full: issue 16 non-ready entries → rs_full=1. Broadcast a tag that completes entry 4 → entry 4 dispatched and rs_full=0 the following cycle; a 17th issue is accepted only then.
- Rollback: 5 busy entries, rollback=1 with simultaneous issue_valid → all entries cleared and the issue dropped; alu_enable=0 and rs_full=0 next cycle.
